// File: rtl/ahb_mtx_pkg.sv
// Shared AHB bus-matrix definitions: transfer/response encodings, input-stage state, control bundle.
package ahb_mtx_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic {PASS = 1'b0, HOLD = 1'b1} instg_state_e;

  typedef struct packed {
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
    logic       hmastlock;
  } ahb_ctrl_t;

  // NONSEQ or SEQ: a transfer the output stages must see
  function automatic logic trans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_mtx_in_hold_reg.sv
// Address/control holding register for a stalled master transfer; loads on load, otherwise keeps.
module ahb_mtx_in_hold_reg
  import ahb_mtx_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          load,
  input  logic [AW-1:0] addr_d,
  input  ahb_ctrl_t     ctrl_d,
  output logic [AW-1:0] addr_q,
  output ahb_ctrl_t     ctrl_q
);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      ctrl_q <= '0;
    end else if (load) begin
      addr_q <= addr_d;
      ctrl_q <= ctrl_d;
    end
  end

endmodule

// File: rtl/ahb_mtx_in_stg.sv
// Bus-matrix input stage: zero-latency address pass-through, holds and stalls the master when the output stage refuses.
// Optional locked-sequence request retention under AHBMTX_INSTG_LOCK_EN.
module ahb_mtx_in_stg
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_OUT = 4,
  parameter int AW      = 32,
  parameter int CNT_W   = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSELS,
  input  logic [AW-1:0]      HADDRS,
  input  logic [1:0]         HTRANSS,
  input  logic               HWRITES,
  input  logic [2:0]         HSIZES,
  input  logic [2:0]         HBURSTS,
  input  logic [3:0]         HPROTS,
  input  logic               HMASTLOCKS,
  input  logic               HREADYS,
  input  logic [NUM_OUT-1:0] sel_dec,
  input  logic               addr_accepted,
  input  logic               data_active,
  input  logic               HREADYM_mux,
  input  logic               HRESPM_mux,
  output logic [AW-1:0]      HADDRI,
  output logic [1:0]         HTRANSI,
  output logic               HWRITEI,
  output logic [2:0]         HSIZEI,
  output logic [2:0]         HBURSTI,
  output logic [3:0]         HPROTI,
  output logic               HMASTLOCKI,
  output logic [NUM_OUT-1:0] req_port,
  output logic               HREADYOUTS,
  output logic               HRESPS,
  output logic [CNT_W-1:0]   hold_cnt
);

  instg_state_e state_q, state_d;
  ahb_ctrl_t    live_ctrl, hold_ctrl, ctrl_i;
  logic [AW-1:0] hold_addr;
  logic         live_valid;
  logic         hold_load;
  logic [NUM_OUT-1:0] lock_req;

  assign live_valid = HSELS & HREADYS & trans_active(HTRANSS);

  always_comb begin
    live_ctrl.htrans = HTRANSS;
    live_ctrl.hwrite = HWRITES;
    live_ctrl.hsize  = HSIZES;
    live_ctrl.hburst = HBURSTS;
    live_ctrl.hprot  = HPROTS;
`ifdef AHBMTX_INSTG_LOCK_EN
    live_ctrl.hmastlock = HMASTLOCKS;
`else
    live_ctrl.hmastlock = 1'b0;
`endif
  end

  ahb_mtx_in_hold_reg #(.AW(AW)) u_hold (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (hold_load),
    .addr_d  (HADDRS),
    .ctrl_d  (live_ctrl),
    .addr_q  (hold_addr),
    .ctrl_q  (hold_ctrl)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= PASS;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hold_load = 1'b0;
    req_port  = '0;
    case (state_q)
      PASS: begin
        req_port = live_valid ? sel_dec : lock_req;
        if (live_valid && !addr_accepted) begin
          hold_load = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // sel_dec decodes HADDRI, which is the held address here
        req_port = sel_dec;
        if (addr_accepted) state_d = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  assign ctrl_i     = (state_q == HOLD) ? hold_ctrl : live_ctrl;
  assign HADDRI     = (state_q == HOLD) ? hold_addr : HADDRS;
  assign HTRANSI    = ctrl_i.htrans;
  assign HWRITEI    = ctrl_i.hwrite;
  assign HSIZEI     = ctrl_i.hsize;
  assign HBURSTI    = ctrl_i.hburst;
  assign HPROTI     = ctrl_i.hprot;
  assign HMASTLOCKI = ctrl_i.hmastlock;

  assign HREADYOUTS = data_active ? HREADYM_mux : (state_q != HOLD);
  assign HRESPS     = data_active ? HRESPM_mux  : HRESP_OKAY;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      hold_cnt <= '0;
    else if ((state_q == HOLD) && (hold_cnt != {CNT_W{1'b1}}))
      hold_cnt <= hold_cnt + CNT_W'(1);
  end

`ifdef AHBMTX_INSTG_LOCK_EN
  logic               lock_vld;
  logic [NUM_OUT-1:0] lock_port;
  logic               xfer_taken;

  // Only a real transfer taken by an output stage updates the lock owner
  assign xfer_taken = addr_accepted & ((state_q == HOLD) | live_valid);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      lock_vld  <= 1'b0;
      lock_port <= '0;
    end else if (xfer_taken) begin
      lock_vld  <= HMASTLOCKI;
      lock_port <= sel_dec;
    end
  end

  assign lock_req = (lock_vld && HMASTLOCKS && (HTRANSS == HTRANS_IDLE)) ? lock_port : '0;
`else
  logic unused_lock;
  assign unused_lock = HMASTLOCKS;
  assign lock_req    = '0;
`endif

endmodule

// File: tb/tb_ahb_mtx_in_stg.sv
// Directed bench for ahb_mtx_in_stg with a transfer-queue reference model checked every cycle.
module tb_ahb_mtx_in_stg;

`ifdef AHBMTX_INSTG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS;
  logic [3:0]  sel_dec;
  logic        addr_accepted, data_active, HREADYM_mux, HRESPM_mux;
  logic [31:0] HADDRI;
  logic [1:0]  HTRANSI;
  logic        HWRITEI, HMASTLOCKI;
  logic [2:0]  HSIZEI, HBURSTI;
  logic [3:0]  HPROTI;
  logic [3:0]  req_port;
  logic        HREADYOUTS, HRESPS;
  logic [7:0]  hold_cnt;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_mtx_in_stg #(.NUM_OUT(4), .AW(32), .CNT_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS), .sel_dec(sel_dec),
    .addr_accepted(addr_accepted), .data_active(data_active),
    .HREADYM_mux(HREADYM_mux), .HRESPM_mux(HRESPM_mux),
    .HADDRI(HADDRI), .HTRANSI(HTRANSI), .HWRITEI(HWRITEI), .HSIZEI(HSIZEI),
    .HBURSTI(HBURSTI), .HPROTI(HPROTI), .HMASTLOCKI(HMASTLOCKI),
    .req_port(req_port), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .hold_cnt(hold_cnt)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: at most one stalled transfer waits in a queue
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } xfer_t;

  xfer_t       pend[$];
  int          stalls = 0;
  bit          lk_prev = 0;
  logic [3:0]  lk_port = '0;

  function automatic xfer_t live_xfer();
    xfer_t x;
    x.addr = HADDRS; x.trans = HTRANSS; x.write = HWRITES; x.size = HSIZES;
    x.burst = HBURSTS; x.prot = HPROTS; x.lock = LOCK ? HMASTLOCKS : 1'b0;
    return x;
  endfunction

  function automatic bit live_ok();
    return HSELS && HREADYS && (HTRANSS == 2'b10 || HTRANSS == 2'b11);
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend.delete();
      stalls  = 0;
      lk_prev = 0;
      lk_port = '0;
    end else if (pend.size() != 0) begin
      stalls++;
      if (addr_accepted) begin
        lk_prev = pend[0].lock;
        lk_port = sel_dec;
        void'(pend.pop_front());
      end
    end else if (live_ok()) begin
      if (addr_accepted) begin
        lk_prev = LOCK ? HMASTLOCKS : 1'b0;
        lk_port = sel_dec;
      end else begin
        pend.push_back(live_xfer());
      end
    end
  end

  always @(negedge HCLK) begin
    xfer_t      e;
    logic [3:0] ereq;
    e = (pend.size() != 0) ? pend[0] : live_xfer();
    if (pend.size() != 0 || live_ok())
      ereq = sel_dec;
    else if (LOCK && HMASTLOCKS && HTRANSS == 2'b00 && lk_prev)
      ereq = lk_port;
    else
      ereq = '0;
    chk("m_haddr",  HADDRI,     e.addr);
    chk("m_htrans", HTRANSI,    e.trans);
    chk("m_hwrite", HWRITEI,    e.write);
    chk("m_hsize",  HSIZEI,     e.size);
    chk("m_hburst", HBURSTI,    e.burst);
    chk("m_hprot",  HPROTI,     e.prot);
    chk("m_hlock",  HMASTLOCKI, e.lock);
    chk("m_req",    req_port,   ereq);
    chk("m_ready",  HREADYOUTS, data_active ? HREADYM_mux : (pend.size() == 0));
    chk("m_resp",   HRESPS,     data_active & HRESPM_mux);
    chk("m_cnt",    hold_cnt,   (stalls > 255) ? 255 : stalls);
  end

  task automatic nxt();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input logic [1:0] tr, input logic [31:0] a, input logic w,
                     input logic [3:0] sd, input logic acc);
    HSELS = 1'b1; HTRANSS = tr; HADDRS = a; HWRITES = w; sel_dec = sd; addr_accepted = acc;
  endtask

  initial begin
    HRESETn = 1'b0; HSELS = 0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 0;
    HSIZES = 3'd2; HBURSTS = 3'd0; HPROTS = 4'h3; HMASTLOCKS = 0; HREADYS = 1;
    sel_dec = '0; addr_accepted = 0; data_active = 0; HREADYM_mux = 1; HRESPM_mux = 0;
    @(negedge HCLK);
    chk("rst_ready", HREADYOUTS, 1'b1);
    chk("rst_resp",  HRESPS,     1'b0);
    chk("rst_req",   req_port,   4'b0000);
    chk("rst_trans", HTRANSI,    2'b00);
    chk("rst_cnt",   hold_cnt,   8'd0);
    nxt();
    HRESETn = 1'b1;
    nxt();

    // zero-latency pass-through
    drv(2'b10, 32'h2000_0010, 1'b0, 4'b0010, 1'b1);
    @(negedge HCLK);
    chk("pass_req",   req_port,   4'b0010);
    chk("pass_addr",  HADDRI,     32'h2000_0010);
    chk("pass_ready", HREADYOUTS, 1'b1);
    chk("pass_cnt",   hold_cnt,   8'd0);

    // refused write -> hold; master address changes are ignored
    nxt();
    drv(2'b10, 32'h4000_0000, 1'b1, 4'b0100, 1'b0);
    @(negedge HCLK);
    chk("pre_hold_ready", HREADYOUTS, 1'b1);
    nxt();
    drv(2'b10, 32'h0000_1234, 1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) nxt();
    @(negedge HCLK);
    chk("hold_addr",  HADDRI,     32'h4000_0000);
    chk("hold_write", HWRITEI,    1'b1);
    chk("hold_ready", HREADYOUTS, 1'b0);
    chk("hold_req",   req_port,   4'b0100);
    chk("hold_cnt3",  hold_cnt,   8'd3);
    addr_accepted = 1'b1;
    nxt();
    drv(2'b00, 32'h0000_1234, 1'b0, 4'b0000, 1'b0);
    @(negedge HCLK);
    chk("back_pass_ready", HREADYOUTS, 1'b1);
    chk("back_pass_req",   req_port,   4'b0000);

    // two-cycle ERROR, next transfer refused on its last cycle
    nxt();
    data_active = 1; HRESPM_mux = 1; HREADYM_mux = 0; HREADYS = 0;
    @(negedge HCLK);
    chk("err1_resp",  HRESPS,     1'b1);
    chk("err1_ready", HREADYOUTS, 1'b0);
    nxt();
    HREADYM_mux = 1; HREADYS = 1;
    drv(2'b10, 32'h5000_0000, 1'b0, 4'b0001, 1'b0);
    @(negedge HCLK);
    chk("err2_resp",  HRESPS,     1'b1);
    chk("err2_ready", HREADYOUTS, 1'b1);
    nxt();
    data_active = 0; HRESPM_mux = 0;
    drv(2'b00, 32'h0, 1'b0, 4'b0001, 1'b1);
    @(negedge HCLK);
    chk("errhold_trans", HTRANSI,    2'b10);
    chk("errhold_addr",  HADDRI,     32'h5000_0000);
    chk("errhold_ready", HREADYOUTS, 1'b0);
    nxt();
    addr_accepted = 0; sel_dec = '0;

    // long hold saturates the counter, then reset mid-hold
    drv(2'b10, 32'h8000_0000, 1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 301; i++) nxt();
    @(negedge HCLK);
    chk("sat_cnt", hold_cnt, 8'd255);
    nxt();
    HTRANSS = 2'b00; HRESETn = 1'b0;
    #1;
    chk("rstmid_req",   req_port,   4'b0000);
    chk("rstmid_ready", HREADYOUTS, 1'b1);
    chk("rstmid_cnt",   hold_cnt,   8'd0);
    nxt();
    HRESETn = 1'b1;
    nxt();

    // locked transfer followed by IDLE with lock still asserted
    HMASTLOCKS = 1'b1;
    drv(2'b10, 32'h3000_0000, 1'b0, 4'b0001, 1'b1);
    @(negedge HCLK);
    chk("lock_nonseq_lk", HMASTLOCKI, LOCK);
    nxt();
    drv(2'b00, 32'h3000_0004, 1'b0, 4'b0100, 1'b0);
    @(negedge HCLK);
    chk("lock_idle_lk",  HMASTLOCKI, LOCK);
    chk("lock_idle_req", req_port,   LOCK ? 4'b0001 : 4'b0000);
    nxt();
    HMASTLOCKS = 1'b0;
    @(negedge HCLK);
    chk("unlock_req", req_port, 4'b0000);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
